// File: rtl/test_card_pkg.sv
// test_card_pkg: constants and types shared by the test card checker and
// any future test card generator. It holds the eight band colours, the band
// count, the error-counter width and the checker FSM state type.
package test_card_pkg;

   localparam int n_bands = 8;
   localparam int err_w   = 16;

   // Band colours as {R,G,B}, from left to right across the line.
   localparam logic [23:0] band_rgb [0:n_bands-1] = '{
      24'hFF0000,
      24'hFFFF00,
      24'h00FF00,
      24'h00FFFF,
      24'h0000FF,
      24'hFF00FF,
      24'h3F3F3F,
      24'h808080
   };

   typedef enum logic [1:0] {
      st_idle  = 2'd0,
      st_blank = 2'd1,
      st_line  = 2'd2,
      st_done  = 2'd3
   } state_t;

   // Band index to colour. Index 8 ("beyond the line") returns black.
   // Callers must not compare pixels in that band.
   function automatic logic [23:0] band_colour(input logic [3:0] band);
      logic [23:0] c;
      c = 24'h000000;
      if (band < 4'(n_bands)) c = band_rgb[band[2:0]];
      return c;
   endfunction

endpackage

// File: rtl/test_card_expect.sv
// test_card_expect: registered lookup from band index to the expected
// 24-bit RGB colour. The result is valid one clock after i_band.
module test_card_expect
   import test_card_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [3:0]  i_band,
   output logic [23:0] o_rgb
);

   // One-cycle colour lookup
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) o_rgb <= 24'h000000;
      else       o_rgb <= band_colour(i_band);
   end

endmodule

// File: rtl/test_card_checker.sv
// test_card_checker: checks a DE-qualified RGB stream against the
// eight-band colour-bar test card and reports one verdict per frame.
// Stream: a pixel is present in every cycle that i_de is high. There is no
// backpressure, and i_frame is a one-cycle strobe sent in blanking.
// Optional feature: define TEST_CARD_CHECKER_FIRST_ERR_EN to add capture of
// the first mismatch of each frame (o_err_x, o_err_y, o_err_rgb).
module test_card_checker #(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_frame,
   input  logic        i_de,
   input  logic [7:0]  i_red,
   input  logic [7:0]  i_green,
   input  logic [7:0]  i_blue,
   output logic        o_frame_done,
   output logic        o_pass,
   output logic [15:0] o_err_count,
   output logic        o_geom_err,
   output logic        o_abort,
   output logic [1:0]  o_state
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
   ,
   output logic [15:0] o_err_x,
   output logic [15:0] o_err_y,
   output logic [23:0] o_err_rgb
`endif
);
   import test_card_pkg::*;

   localparam int          hw       = H_RES / n_bands;
   localparam logic [15:0] h_res_w  = 16'(H_RES);
   localparam logic [15:0] v_res_w  = 16'(V_RES);
   localparam logic [15:0] sub_last = 16'(hw - 1);

   state_t             state, nxt_state;
   logic               f1, de1, de1_q;
   logic [23:0]        rgb1;
   logic               de_rise, de_fall;
   logic [15:0]        x, sub, y;
   logic [3:0]         band;
   logic [15:0]        cur_x, cur_sub;
   logic [3:0]         cur_band;
   logic               restart, abort_now, line_end, extra_line, chk_en;
   logic               chk2, mis;
   logic [23:0]        rgb2, exp_rgb;
   logic [err_w-1:0]   err;
   logic               geom;

   // Stage 1: register the raw stream. All checking uses these copies.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         f1    <= 1'b0;
         de1   <= 1'b0;
         de1_q <= 1'b0;
         rgb1  <= 24'h000000;
      end else begin
         f1    <= i_frame;
         de1   <= i_de;
         de1_q <= de1;
         rgb1  <= {i_red, i_green, i_blue};
      end
   end

   assign de_rise = de1 & ~de1_q;
   assign de_fall = ~de1 & de1_q;

   // Position of the stage-1 pixel. A DE rise restarts the line at x = 0.
   assign cur_x    = de_rise ? 16'd0 : x;
   assign cur_sub  = de_rise ? 16'd0 : sub;
   assign cur_band = de_rise ? 4'd0  : band;

   // FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= st_idle;
      else       state <= nxt_state;
   end

   // Next state and frame events. A frame strobe is applied before a DE
   // rise in the same cycle.
   always_comb begin
      nxt_state  = state;
      restart    = 1'b0;
      abort_now  = 1'b0;
      line_end   = 1'b0;
      extra_line = 1'b0;
      case (state)
         st_idle: begin
            if (f1) begin
               restart   = 1'b1;
               nxt_state = de_rise ? st_line : st_blank;
            end
         end
         st_blank: begin
            if (f1) begin
               restart   = 1'b1;
               // y == V_RES only after DONE, so a completed frame is not aborted.
               abort_now = (y != 16'd0) && (y != v_res_w);
               nxt_state = de_rise ? st_line : st_blank;
            end else if (de_rise) begin
               if (y == v_res_w) extra_line = 1'b1;
               else              nxt_state  = st_line;
            end
         end
         st_line: begin
            if (f1) begin
               restart   = 1'b1;
               abort_now = 1'b1;
               nxt_state = st_blank;
            end else if (de_fall) begin
               line_end  = 1'b1;
               nxt_state = ((y + 16'd1) == v_res_w) ? st_done : st_blank;
            end
         end
         st_done: begin
            if (f1) begin
               restart   = 1'b1;
               nxt_state = de_rise ? st_line : st_blank;
            end else begin
               nxt_state = st_blank;
            end
         end
         default: nxt_state = st_idle;
      endcase
   end

   // Check only pixels that belong to a line of the frame and lie inside
   // the eight bands.
   assign chk_en = de1 && (nxt_state == st_line) && (cur_band < 4'(n_bands));

   // Pixel, sub-band and band counters. The band holds at 8 past H_RES.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         x    <= 16'd0;
         sub  <= 16'd0;
         band <= 4'd0;
      end else if (de1) begin
         x <= (cur_x != 16'hFFFF) ? cur_x + 16'd1 : cur_x;
         if (cur_sub == sub_last) begin
            sub  <= 16'd0;
            band <= (cur_band == 4'(n_bands)) ? cur_band : cur_band + 4'd1;
         end else begin
            sub  <= cur_sub + 16'd1;
            band <= cur_band;
         end
      end
   end

   test_card_expect u_expect (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_band (cur_band),
      .o_rgb  (exp_rgb)
   );

`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
   logic [15:0] x2, y2;
   logic        fe_valid;
   logic [15:0] fe_x, fe_y;
   logic [23:0] fe_rgb;
`endif

   // Stage 2: align the pixel with its expected colour
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         chk2 <= 1'b0;
         rgb2 <= 24'h000000;
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
         x2   <= 16'd0;
         y2   <= 16'd0;
`endif
      end else begin
         chk2 <= chk_en;
         rgb2 <= rgb1;
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
         x2   <= cur_x;
         y2   <= restart ? 16'd0 : y;
`endif
      end
   end

   assign mis = chk2 && (rgb2 != exp_rgb);

   // Per-frame line count, saturating error count and geometry flag
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         y    <= 16'd0;
         err  <= '0;
         geom <= 1'b0;
      end else if (restart) begin
         y    <= 16'd0;
         err  <= '0;
         geom <= 1'b0;
      end else begin
         if (line_end) begin
            y <= y + 16'd1;
            if (x != h_res_w) geom <= 1'b1;
         end
         if (mis && (err != '1)) err <= err + err_w'(1);
      end
   end

`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
   // Capture the first mismatch of the frame
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fe_valid <= 1'b0;
         fe_x     <= 16'd0;
         fe_y     <= 16'd0;
         fe_rgb   <= 24'h000000;
      end else if (restart) begin
         fe_valid <= 1'b0;
         fe_x     <= 16'd0;
         fe_y     <= 16'd0;
         fe_rgb   <= 24'h000000;
      end else if (mis && !fe_valid) begin
         fe_valid <= 1'b1;
         fe_x     <= x2;
         fe_y     <= y2;
         fe_rgb   <= rgb2;
      end
   end
`endif

   // Verdict outputs: latched in DONE. A line after the final line of a
   // completed frame updates that frame's verdict.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_frame_done <= 1'b0;
         o_abort      <= 1'b0;
         o_pass       <= 1'b0;
         o_err_count  <= 16'd0;
         o_geom_err   <= 1'b0;
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
         o_err_x      <= 16'd0;
         o_err_y      <= 16'd0;
         o_err_rgb    <= 24'h000000;
`endif
      end else begin
         o_frame_done <= (state == st_done);
         o_abort      <= abort_now;
         if (state == st_done) begin
            o_pass      <= (err == '0) && !geom;
            o_err_count <= err;
            o_geom_err  <= geom;
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
            o_err_x     <= fe_x;
            o_err_y     <= fe_y;
            o_err_rgb   <= fe_rgb;
`endif
         end else if (extra_line) begin
            o_pass     <= 1'b0;
            o_geom_err <= 1'b1;
         end
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_test_card_checker.sv
// tb_test_card_checker: randomized frames for a small 128x12 checker,
// checked against a raster-level reference model through an expected-verdict
// queue. A second 512x130 instance runs an all-wrong frame to reach the
// saturation limit of the error counter.
module tb_test_card_checker;

  localparam int H   = 128;
  localparam int V   = 12;
  localparam int HWB = H / 8;
  localparam int SH  = 512;
  localparam int SV  = 130;

  localparam logic [23:0] ref_col [8] = '{
    24'hFF0000, 24'hFFFF00, 24'h00FF00, 24'h00FFFF,
    24'h0000FF, 24'hFF00FF, 24'h3F3F3F, 24'h808080
  };

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, s_rst;

  // main DUT signals
  logic        frame, de;
  logic [23:0] rgb;
  logic        frame_done, pass, geom_err, abort;
  logic [15:0] err_count;
  logic [1:0]  dbg_state;
  // saturation DUT signals
  logic        s_frame, s_de;
  logic [23:0] s_rgb;
  logic        s_done, s_pass, s_geom, s_abort;
  logic [15:0] s_err;
  logic [1:0]  s_state;
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
  logic [15:0] err_x, err_y, s_ex, s_ey;
  logic [23:0] err_rgb, s_ergb;
`endif

  test_card_checker #(.H_RES(H), .V_RES(V)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame(frame), .i_de(de),
    .i_red(rgb[23:16]), .i_green(rgb[15:8]), .i_blue(rgb[7:0]),
    .o_frame_done(frame_done), .o_pass(pass), .o_err_count(err_count),
    .o_geom_err(geom_err), .o_abort(abort), .o_state(dbg_state)
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
    , .o_err_x(err_x), .o_err_y(err_y), .o_err_rgb(err_rgb)
`endif
  );

  test_card_checker #(.H_RES(SH), .V_RES(SV)) u_sat (
    .i_clk(clk), .i_rst(s_rst), .i_frame(s_frame), .i_de(s_de),
    .i_red(s_rgb[23:16]), .i_green(s_rgb[15:8]), .i_blue(s_rgb[7:0]),
    .o_frame_done(s_done), .o_pass(s_pass), .o_err_count(s_err),
    .o_geom_err(s_geom), .o_abort(s_abort), .o_state(s_state)
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
    , .o_err_x(s_ex), .o_err_y(s_ey), .o_err_rgb(s_ergb)
`endif
  );

  // scoreboard state
  int n_cmp = 0;
  int n_fail = 0;
  int n_abort_seen = 0;
  int exp_aborts = 0;
  // {pass, geom, err[15:0], fx[15:0], fy[15:0], frgb[23:0]}
  logic [73:0] exp_q[$];

  // reference model of the frame being driven
  logic [15:0] m_err, m_fx, m_fy;
  logic        m_geom, m_fe_valid;
  logic [23:0] m_frgb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // driver tasks: one call per clock, inputs change 1 time unit after the edge
  task automatic cyc(input logic f, input logic d, input logic [23:0] c);
    frame = f; de = d; rgb = c;
    @(posedge clk); #1;
  endtask

  task automatic s_cyc(input logic f, input logic d, input logic [23:0] c);
    s_frame = f; s_de = d; s_rgb = c;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 24'h0);
  endtask

  // One line. Pixels in x < H that differ from the card are model errors.
  task automatic drive_line(input int len, input int yy, input int err_pct, input int fx,
                            input int fy, input int frame_x, input bit count);
    for (int x = 0; x < len; x++) begin
      logic [23:0] e, c;
      e = (x < H) ? ref_col[x / HWB] : 24'h0;
      c = e;
      if (x >= H) c = 24'($urandom);
      else if (x == fx && yy == fy) c = 24'h000000;
      else if ($urandom_range(0, 99) < err_pct) c = e ^ 24'($urandom_range(1, 24'hFFFFFF));
      if (count && x < H && c != e) begin
        if (m_err != 16'hFFFF) m_err++;
        if (!m_fe_valid) begin
          m_fe_valid = 1'b1; m_fx = 16'(x); m_fy = 16'(yy); m_frgb = c;
        end
      end
      cyc(x == frame_x, 1'b1, c);
    end
    if (count && len != H) m_geom = 1'b1;
  endtask

  task automatic push_expected();
    logic p;
    p = (m_err == 16'd0) && !m_geom;
    exp_q.push_back({p, m_geom, m_err, m_fx, m_fy, m_frgb});
  endtask

  // Asynchronous reset in the middle of a line; outputs must clear at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_async_done", frame_done, 0);
    check("rst_async_pass", pass, 0);
    check("rst_async_err", err_count, 0);
    check("rst_async_geom", geom_err, 0);
    check("rst_async_abort", abort, 0);
    frame = 1'b0; de = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One frame: a low cycle, then the frame strobe (or the strobe on the first
  // pixel when at_rise is set), then lines with random horizontal blanking.
  task automatic run_frame(input int nlines, input int short_y, input int err_pct, input int fx,
                           input int fy, input int abort_y, input int rst_y, input bit at_rise);
    m_err = 0; m_geom = 0; m_fe_valid = 0; m_fx = 0; m_fy = 0; m_frgb = 0;
    cyc(1'b0, 1'b0, 24'h0);
    if (!at_rise) cyc(1'b1, 1'b0, 24'h0);
    for (int y = 0; y < nlines; y++) begin
      if (!(at_rise && y == 0)) repeat ($urandom_range(2, 6)) cyc(1'b0, 1'b0, 24'h0);
      if (y == rst_y) begin
        drive_line(30, y, 0, -1, -1, -1, 1'b0);
        do_reset();
        return;
      end
      if (y == abort_y) begin
        exp_aborts++;
        drive_line(H, y, 0, -1, -1, 50, 1'b0);
        return;
      end
      drive_line((y == short_y) ? H - 1 : H, y, err_pct, fx, fy,
                 (at_rise && y == 0) ? 0 : -1, y < V);
      if (y == V - 1) push_expected();
    end
  endtask

  // monitor: pop one expected verdict per frame_done, count abort pulses
  always @(negedge clk) begin
    logic [73:0] e;
    if (abort) n_abort_seen++;
    if (frame_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pass", pass, e[73]);
        check("geom_err", geom_err, e[72]);
        check("err_count", err_count, e[71:56]);
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
        check("err_x", err_x, e[55:40]);
        check("err_y", err_y, e[39:24]);
        check("err_rgb", err_rgb, e[23:0]);
`endif
      end
    end
  end

  task automatic main_seq();
    run_frame(V, -1, 0, -1, -1, -1, -1, 1'b0);        // perfect frame
    run_frame(V, -1, 0, 100, 7, -1, -1, 1'b0);        // one black pixel at (100,7)
    run_frame(V, 3, 0, -1, -1, -1, -1, 1'b0);         // one short line
    run_frame(V + 1, -1, 0, -1, -1, -1, -1, 1'b0);    // one extra line
    idle(10);
    check("extra_line_geom", geom_err, 1);
    check("extra_line_pass", pass, 0);
    for (int i = 0; i < 4; i++)
      run_frame(V, -1, int'($urandom_range(0, 2)), -1, -1, -1, -1, 1'b0);
    run_frame(V, -1, 1, -1, -1, -1, -1, 1'b1);        // strobe with first DE
    run_frame(V, -1, 0, -1, -1, -1, -1, 1'b0);        // back-to-back pair
    run_frame(V, -1, 0, 5, 0, -1, -1, 1'b0);
    run_frame(V, -1, 0, -1, -1, 10, -1, 1'b0);        // strobe mid-line 10
    run_frame(V, -1, 0, -1, -1, -1, -1, 1'b0);
    run_frame(V, -1, 0, 20, 2, -1, -1, 1'b0);         // leaves non-zero outputs
    idle(10);
    run_frame(V, -1, 0, -1, -1, -1, 6, 1'b0);         // reset at line 6
    run_frame(V, -1, 0, -1, -1, -1, -1, 1'b0);
    idle(20);
  endtask

  // every pixel wrong on the large instance; the count must stop at FFFF
  task automatic sat_seq();
    bit got;
    logic [31:0] n_bad;
    s_cyc(1'b0, 1'b0, 24'h0);
    s_cyc(1'b1, 1'b0, 24'h0);
    for (int y = 0; y < SV; y++) begin
      repeat (2) s_cyc(1'b0, 1'b0, 24'h0);
      repeat (SH) s_cyc(1'b0, 1'b1, 24'h123456);
    end
    s_de = 1'b0;
    n_bad = SH * SV;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (s_done) begin
        got = 1'b1;
        check("sat_err_count", s_err, (n_bad > 32'hFFFF) ? 32'hFFFF : n_bad);
        check("sat_pass", s_pass, 0);
        check("sat_geom", s_geom, 0);
      end
    end
    if (!got) check("sat_frame_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; s_rst = 1'b1;
    frame = 1'b0; de = 1'b0; rgb = 24'h0;
    s_frame = 1'b0; s_de = 1'b0; s_rgb = 24'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_frame_done", frame_done, 0);
    check("reset_pass", pass, 0);
    check("reset_err_count", err_count, 0);
    check("reset_geom_err", geom_err, 0);
    check("reset_abort", abort, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b0; s_rst = 1'b0;
    fork
      main_seq();
      sat_seq();
    join
    check("pending_frames", exp_q.size(), 0);
    check("abort_count", n_abort_seen, exp_aborts);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
